// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
//   Sequences the core's instruction-fetch and data-memory requests onto a
//   single AXI master port. Only one single-beat word transaction is in flight
//   at any time. Data requests have fixed priority over fetches.
//
// Ports
//   a_clk, a_resetn              clock, async active-low reset
//   if_req/if_addr               fetch request (level) and word address
//   if_rdata/if_done/if_fault    registered fetch data, completion pulse, fault
//   d_req/d_we/d_addr/d_wdata/d_wmask  data request, write enable, payload
//   d_rdata/d_done/d_err         registered load data, completion pulse, error
//   aw_*/w_*/b_*                 AXI write address, write data, write response
//   ar_*/r_*                     AXI read address, read data
module axi_mem_arbiter #(
    parameter logic [3:0] IF_ID = 4'b1000,
    parameter logic [3:0] D_ID  = 4'b0000
) (
    input  logic        a_clk,
    input  logic        a_resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_fault,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic [3:0]  aw_id,
    output logic [31:0] aw_addr,
    output logic [3:0]  aw_len,
    output logic [2:0]  aw_size,
    output logic [1:0]  aw_burst,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [3:0]  w_id,
    output logic [31:0] w_data,
    output logic [3:0]  w_strb,
    output logic        w_last,
    output logic        w_valid,
    input  logic        w_ready,
    input  logic [3:0]  b_id,
    input  logic [1:0]  b_resp,
    input  logic        b_valid,
    output logic        b_ready,
    output logic [3:0]  ar_id,
    output logic [31:0] ar_addr,
    output logic [3:0]  ar_len,
    output logic [2:0]  ar_size,
    output logic [1:0]  ar_burst,
    output logic        ar_valid,
    input  logic        ar_ready,
    input  logic [3:0]  r_id,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    input  logic        r_last,
    input  logic        r_valid,
    output logic        r_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RADDR = 3'd1;
    localparam logic [2:0] S_RDATA = 3'd2;
    localparam logic [2:0] S_WADDR = 3'd3;
    localparam logic [2:0] S_WRESP = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_strb;
    logic [3:0]  lat_id;
    logic        own_d;      // 1: current transaction belongs to the data port
    logic        err_q;
    logic        aw_ok;
    logic        w_ok;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    logic aw_hs;
    logic w_hs;

    assign aw_hs = aw_valid & aw_ready;
    assign w_hs  = w_valid & w_ready;

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state      <= S_IDLE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_strb   <= '0;
            lat_id     <= '0;
            own_d      <= 1'b0;
            err_q      <= 1'b0;
            aw_ok      <= 1'b0;
            w_ok       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    aw_ok <= 1'b0;
                    w_ok  <= 1'b0;
                    if (d_req) begin
                        own_d     <= 1'b1;
                        lat_addr  <= d_addr;
                        lat_wdata <= d_wdata;
                        lat_strb  <= d_wmask;
                        lat_id    <= D_ID;
                        state     <= d_we ? S_WADDR : S_RADDR;
                    end else if (if_req) begin
                        own_d     <= 1'b0;
                        lat_addr  <= if_addr;
                        lat_wdata <= '0;
                        lat_strb  <= '0;
                        lat_id    <= IF_ID;
                        state     <= S_RADDR;
                    end
                end
                S_RADDR: begin
                    if (ar_ready) state <= S_RDATA;
                end
                S_RDATA: begin
                    if (r_valid) begin
                        if (own_d) d_rdata_q  <= r_data;
                        else       if_rdata_q <= r_data;
                        err_q <= (r_resp != 2'b00) | ~r_last | (r_id != lat_id);
                        state <= S_DONE;
                    end
                end
                S_WADDR: begin
                    if (aw_hs) aw_ok <= 1'b1;
                    if (w_hs)  w_ok  <= 1'b1;
                    // Address and data channels may complete in either order
                    // or together; leave only once both have been accepted.
                    if ((aw_ok | aw_hs) && (w_ok | w_hs)) state <= S_WRESP;
                end
                S_WRESP: begin
                    if (b_valid) begin
                        err_q <= (b_resp != 2'b00) | (b_id != D_ID);
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ar_valid = (state == S_RADDR);
    assign ar_id    = lat_id;
    assign ar_addr  = lat_addr;
    assign ar_len   = 4'd0;
    assign ar_size  = 3'b010;
    assign ar_burst = 2'b01;
    assign r_ready  = (state == S_RDATA);

    assign aw_valid = (state == S_WADDR) & ~aw_ok;
    assign aw_id    = lat_id;
    assign aw_addr  = lat_addr;
    assign aw_len   = 4'd0;
    assign aw_size  = 3'b010;
    assign aw_burst = 2'b01;
    assign w_valid  = (state == S_WADDR) & ~w_ok;
    assign w_id     = lat_id;
    assign w_data   = lat_wdata;
    assign w_strb   = lat_strb;
    assign w_last   = 1'b1;
    assign b_ready  = (state == S_WRESP);

    assign if_done  = (state == S_DONE) & ~own_d;
    assign if_fault = if_done & err_q;
    assign if_rdata = if_rdata_q;
    assign d_done   = (state == S_DONE) & own_d;
    assign d_err    = d_done & err_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Single-master AXI sequencer between the RISC-V core's instruction-fetch and data-memory ports and one AXI master interface. It arbitrates the two requesters, issues exactly one single-beat word transaction at a time, and tracks the full AR/R or AW/W/B handshake sequence. It returns registered read data, completion pulses and error flags that the core uses as fetch/data stall and fault inputs.

## Interface
- IF_ID, 4'b1000: AXI ID for instruction fetches (bit 3 set).
- D_ID, 4'b0000: AXI ID for data accesses.
- a_clk  in  1  clock; all logic rising-edge.
- a_resetn  in  1  reset, asynchronous, active-low.
- if_req / if_addr  in  1 / 32  fetch request (level, held until if_done) and word address.
- if_rdata  out  32  registered fetch data; valid when if_done.
- if_done / if_fault  out  1 / 1  one-cycle completion pulse; fault qualifies it.
- d_req / d_we  in  1 / 1  data request (level, held until d_done); 1 = write.
- d_addr / d_wdata / d_wmask  in  32 / 32 / 4  data address, write data, byte strobes.
- d_rdata  out  32  registered load data; valid when d_done & ~d_we.
- d_done / d_err  out  1 / 1  one-cycle completion pulse; err qualifies it.
- aw_id, aw_addr, aw_valid  out  4, 32, 1; aw_ready  in  1.
- w_id, w_data, w_strb, w_valid  out  4, 32, 4, 1; w_last  out  1  constant 1; w_ready  in  1.
- b_id, b_resp, b_valid  in  4, 2, 1; b_ready  out  1.
- ar_id, ar_addr, ar_valid  out  4, 32, 1; ar_ready  in  1.
- r_id, r_data, r_resp, r_last, r_valid  in  4, 32, 2, 1, 1; r_ready  out  1.
- aw_len/ar_len  out 4  const 0; aw_size/ar_size  out 3  const 3'b010; aw_burst/ar_burst  out 2  const 2'b01 (INCR).

## Operation
- States: IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
- IDLE arbitration, fixed priority: d_req wins over if_req. Winner's address/data/strobes/we/ID latched into internal registers; AXI outputs driven only from these registers.
- Winner read (fetch, or data with d_we=0) -> RADDR; data write -> WADDR.
- RADDR: ar_valid=1, ar_id/ar_addr from latch. On ar_valid&ar_ready -> RDATA.
- RDATA: r_ready=1. On r_valid: capture r_data into the requester's rdata register; error = (r_resp!=0) | ~r_last | (r_id!=latched ID) -> DONE.
- WADDR: aw_valid and w_valid both asserted on entry; each drops independently after its own handshake (flags aw_ok, w_ok). When both complete (same or different cycles) -> WRESP. w_id = aw_id.
- WRESP: b_ready=1. On b_valid: error = (b_resp!=0) | (b_id!=D_ID) -> DONE.
- DONE: one cycle; pulse if_done or d_done for the owner, with if_fault/d_err = captured error; -> IDLE.
- Exactly one outstanding transaction; no valid asserted outside its state; ready asserted only in RDATA/WRESP.
- Requester drops req in the cycle its done is high; a req still high in the following IDLE cycle is a new request.
- Request inputs are ignored outside IDLE; changes mid-transaction have no effect.

## Timing
- Reset (async assert, sync release): state=IDLE; all valids, readys, done, fault, err = 0; rdata registers = 0; latched addr/data/ID = 0.
- Read, zero-wait slave: req seen in IDLE cycle 0; ar_valid cycle 1 (ar_ready same cycle); r_ready cycle 2 with r_valid; done pulse cycle 3. Minimum 4 cycles req-to-done; min write likewise 4 (aw/w cycle 1, b cycle 2, done 3).
- ar_valid/aw_valid/w_valid once raised stay high with stable payload until handshake (AXI rule).
- Simultaneous if_req and d_req: data served first; fetch served in the IDLE cycle after d_done.
- Responses arriving before the matching ready state are not accepted (ready low).
- Reset mid-transaction: outputs drop immediately; no done pulse; slave is reset by the same a_resetn.
- Back-to-back: DONE->IDLE->new addr phase; one idle bubble between transactions.

## Test plan
- Reset: hold a_resetn=0 with if_req=1 -> all valids/readys/done 0; release -> ar_valid=1, ar_id=4'b1000 two cycles later.
- Fetch 0x0000_0100, slave returns 0x0000_0013, resp 0, ar_ready/r_valid zero-wait -> if_done on cycle 3, if_rdata=0x13, if_fault=0.
- Store 0x1000_0004, data 0xDEADBEEF, mask 4'b0011; w_ready 3 cycles after aw_ready -> aw_valid drops first, w_valid held, then b; d_done, d_err=0; aw_id=w_id=0.
- if_req and d_req (load) same cycle -> AR with ar_addr=d_addr, ID 0 first; fetch AR issued after d_done.
- Load with r_resp=2'b10 -> d_done with d_err=1; fetch with r_last=0 -> if_fault=1; write with b_resp=2'b11 -> d_err=1.
- Assert a_resetn=0 in RDATA -> r_ready and done stay 0; after release state IDLE, next request proceeds normally.
